attenuator_scheduler: RTL

// - Time-multiplexes one signed BITSIZE x BITSIZE multiplier across CHANNELS audio channels.
// - Each channel is scaled by its own gain, with the same scaling as the attenuator core:
//   out = product[2*BITSIZE-2 -: BITSIZE].
// - Ramps each channel's applied gain toward its target by at most RAMP_STEP per frame,

---
 rtl/attenuator_scheduler_if.sv | 24 ++
 rtl/attenuator_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/attenuator_scheduler_if.sv
// Frame-level bus of the attenuator scheduler: strobe, packed samples/gains in,
// packed scaled samples and status out.
interface attenuator_scheduler_if #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 4
);
    logic                         sample_strobe;
    logic [CHANNELS*BITSIZE-1:0]  in_data;
    logic [CHANNELS*BITSIZE-1:0]  target_att;
    logic [CHANNELS*BITSIZE-1:0]  out_data;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_strobe, in_data, target_att,
        input  out_data, out_valid, busy, overrun
    );

    modport slave (
        input  sample_strobe, in_data, target_att,
        output out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/attenuator_scheduler.sv
// Shares one signed multiplier across all channels, ramping each channel's gain toward
// its target by at most RAMP_STEP per frame and publishing all channels together.
//
// state | meaning
// IDLE  | waiting for sample_strobe; out_data holds the last frame
// RUN   | issuing one channel per cycle to the multiplier, updating its gain
// DONE  | phase 0: last product lands in shadow; phase 1: shadow -> out_data
module attenuator_scheduler #(
    parameter int BITSIZE   = 16,
    parameter int CHANNELS  = 4,
    parameter int RAMP_STEP = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    attenuator_scheduler_if.slave  bus
);
    localparam int B     = BITSIZE;
    localparam int W     = BITSIZE * CHANNELS;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       prod_idx_q;
    logic                   prod_vld_q;
    logic                   done_ph_q;
    logic                   out_valid_q;
    logic                   overrun_q;
    logic [W-1:0]           in_lat_q;
    logic [W-1:0]           tgt_lat_q;
    logic [W-1:0]           out_data_q;
    logic signed [2*B-1:0]  prod_q;
    logic signed [B-1:0]    cur_att_q [CHANNELS];
    logic signed [B-1:0]    shadow_q  [CHANNELS];

    logic signed [2*B-1:0]  prod_d;
    logic signed [B-1:0]    gain_d;
    logic signed [B-1:0]    samp_sel;
    logic signed [B-1:0]    gain_sel;
    logic signed [B-1:0]    tgt_sel;
    logic [W-1:0]           shadow_flat;

    // Difference taken one bit wider so the step never wraps or overshoots the target.
    function automatic logic signed [B-1:0] ramp(input logic signed [B-1:0] cur,
                                                 input logic signed [B-1:0] tgt);
        logic signed [B:0] cur_w;
        logic signed [B:0] tgt_w;
        logic signed [B:0] step;
        logic signed [B:0] d;
        logic signed [B:0] nxt;
        cur_w = {cur[B-1], cur};
        tgt_w = {tgt[B-1], tgt};
        step  = (B+1)'(RAMP_STEP);
        d     = tgt_w - cur_w;
        if (d > step) begin
            nxt = cur_w + step;
        end else if (d < -step) begin
            nxt = cur_w - step;
        end else begin
            nxt = tgt_w;
        end
        return nxt[B-1:0];
    endfunction

    always_comb begin
        samp_sel = in_lat_q[int'(idx_q)*B +: B];
        tgt_sel  = tgt_lat_q[int'(idx_q)*B +: B];
        gain_sel = cur_att_q[idx_q];
        prod_d   = samp_sel * gain_sel;
        gain_d   = ramp(gain_sel, tgt_sel);
        shadow_flat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            shadow_flat[k*B +: B] = shadow_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            prod_idx_q  <= '0;
            prod_vld_q  <= 1'b0;
            done_ph_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            in_lat_q    <= '0;
            tgt_lat_q   <= '0;
            out_data_q  <= '0;
            prod_q      <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                cur_att_q[k] <= '0;
                shadow_q[k]  <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            prod_vld_q  <= 1'b0;

            if (prod_vld_q) begin
                shadow_q[prod_idx_q] <= prod_q[2*B-2 -: B];
            end

            if (bus.sample_strobe && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    done_ph_q <= 1'b0;
                    if (bus.sample_strobe) begin
                        in_lat_q  <= bus.in_data;
                        tgt_lat_q <= bus.target_att;
                        idx_q     <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    prod_q            <= prod_d;
                    prod_idx_q        <= idx_q;
                    prod_vld_q        <= 1'b1;
                    cur_att_q[idx_q]  <= gain_d;
                    if (idx_q == IDX_W'(CHANNELS - 1)) begin
                        state_q   <= DONE;
                        done_ph_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!done_ph_q) begin
                        done_ph_q <= 1'b1;
                    end else begin
                        out_data_q  <= shadow_flat;
                        out_valid_q <= 1'b1;
                        done_ph_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule
